// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, the per-pixel control bundle and the colour expansion rule.
// The framebuffer reader imports the same constants so both sides agree on frame geometry.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef struct packed {
    logic den;
    logic hs;
    logic vs;
  } vga_ctl_t;

  // Left-justify a w-bit colour (held in the low bits of c) and refill the
  // low bits by cycling through the source bits again from its MSB.
  function automatic logic [7:0] expand_color(input logic [7:0] c, input int unsigned w);
    logic [7:0]  e;
    int unsigned src;
    e   = 8'h00;
    src = 32'd0;
    if ((w == 32'd0) || (w > 32'd8)) begin
      e = 8'h00;
    end else begin
      for (int unsigned i = 32'd0; i < 32'd8; i++) begin
        src = w - 32'd1 - (i % w);
        e[3'(32'd7 - i)] = c[3'(src)];
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-side and pin-side signals of the VGA timing generator.
// The generator is the master; the framebuffer reader and the pads are the slave side.
interface vga_timing_gen_if #(
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int FC_W    = 6,
  parameter int COLOR_W = 6
);
  logic [XW-1:0]      x_out;
  logic [YW-1:0]      y_out;
  logic [FC_W-1:0]    fc_out;
  logic               fb_en_out;
  logic               draw_en_out;
  logic               line_start_out;
  logic               frame_start_out;
  logic [COLOR_W-1:0] r_in;
  logic [COLOR_W-1:0] g_in;
  logic [COLOR_W-1:0] b_in;
  logic               VGA_CLK;
  logic [7:0]         VGA_R;
  logic [7:0]         VGA_G;
  logic [7:0]         VGA_B;
  logic               VGA_HS;
  logic               VGA_VS;
  logic               VGA_BLANK_N;

  modport master (
    output x_out, y_out, fc_out, fb_en_out, draw_en_out, line_start_out, frame_start_out,
    output VGA_CLK, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
    input  r_in, g_in, b_in
  );

  modport slave (
    input  x_out, y_out, fc_out, fb_en_out, draw_en_out, line_start_out, frame_start_out,
    input  VGA_CLK, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N,
    output r_in, g_in, b_in
  );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with asynchronous reset to a programmable value.
// Used to line the blank/sync controls up with the framebuffer read latency.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int           W       = 1,
  parameter int           DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_r [DEPTH];

  // shift d through DEPTH register stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= RST_VAL;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line/frame counters for the framebuffer reader,
// plus sync, blank and colour pins aligned to the reader's fixed read latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 6,
  parameter int PIPE_LAT = 1,
  parameter int FC_W     = 6
) (
  input logic              clk,
  input logic              rst,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW       = $clog2(H_TOTAL);
  localparam int YW       = $clog2(V_TOTAL);
  localparam int HS_FIRST = H_ACTIVE + H_FP;
  localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_FIRST = V_ACTIVE + V_FP;
  localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

  // Pin level while the sync pulse is idle.
  localparam logic HS_IDLE = (HS_POL == 0) ? 1'b1 : 1'b0;
  localparam logic VS_IDLE = (VS_POL == 0) ? 1'b1 : 1'b0;

  logic [XW-1:0]   x_r;
  logic [YW-1:0]   y_r;
  logic [FC_W-1:0] fc_r;
  logic [XW-1:0]   x_nxt_s;
  logic [YW-1:0]   y_nxt_s;
  logic [FC_W-1:0] fc_nxt_s;
  logic            x_last_s;
  logic            y_last_s;
  logic            fb_en_s;
  vga_ctl_t        ctl_s;
  vga_ctl_t        ctl_d_s;

  assign x_last_s = (x_r == XW'(H_TOTAL - 1));
  assign y_last_s = (y_r == YW'(V_TOTAL - 1));
  assign fb_en_s  = (x_r < XW'(H_ACTIVE)) && (y_r < YW'(V_ACTIVE));

  // next-count logic: the frame counter steps on the same edge that wraps x and y
  always_comb begin
    x_nxt_s  = x_r + XW'(1);
    y_nxt_s  = y_r;
    fc_nxt_s = fc_r;
    if (x_last_s) begin
      x_nxt_s = '0;
      if (y_last_s) begin
        y_nxt_s  = '0;
        fc_nxt_s = fc_r + FC_W'(1);
      end else begin
        y_nxt_s  = y_r + YW'(1);
        fc_nxt_s = fc_r;
      end
    end else begin
      x_nxt_s = x_r + XW'(1);
    end
  end

  // counter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r  <= '0;
      y_r  <= '0;
      fc_r <= '0;
    end else begin
      x_r  <= x_nxt_s;
      y_r  <= y_nxt_s;
      fc_r <= fc_nxt_s;
    end
  end

  // raw enable and sync windows decoded from the current counters
  always_comb begin
    ctl_s     = '0;
    ctl_s.den = fb_en_s;
    ctl_s.hs  = (x_r >= XW'(HS_FIRST)) && (x_r <= XW'(HS_LAST));
    ctl_s.vs  = (y_r >= YW'(VS_FIRST)) && (y_r <= YW'(VS_LAST));
  end

  // One stage to register the decode glitch-free, then PIPE_LAT stages for the read latency.
  vga_delay_line #(
    .W       ($bits(vga_ctl_t)),
    .DEPTH   (PIPE_LAT + 1),
    .RST_VAL ('0)
  ) u_ctl_dly (
    .clk (clk),
    .rst (rst),
    .d   (ctl_s),
    .q   (ctl_d_s)
  );

  assign bus.x_out           = x_r;
  assign bus.y_out           = y_r;
  assign bus.fc_out          = fc_r;
  assign bus.fb_en_out       = fb_en_s;
  assign bus.draw_en_out     = (y_r >= YW'(V_ACTIVE));
  assign bus.line_start_out  = (x_r == XW'(0));
  assign bus.frame_start_out = (x_r == XW'(0)) && (y_r == YW'(0));

  assign bus.VGA_CLK     = clk;
  assign bus.VGA_HS      = ctl_d_s.hs ^ HS_IDLE;
  assign bus.VGA_VS      = ctl_d_s.vs ^ VS_IDLE;
  assign bus.VGA_BLANK_N = ctl_d_s.den;
  assign bus.VGA_R       = ctl_d_s.den ? expand_color(8'(bus.r_in), COLOR_W) : 8'h00;
  assign bus.VGA_G       = ctl_d_s.den ? expand_color(8'(bus.g_in), COLOR_W) : 8'h00;
  assign bus.VGA_B       = ctl_d_s.den ? expand_color(8'(bus.b_in), COLOR_W) : 8'h00;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four configurations run side by side against a closed-form
// model (counters and delayed controls derived from the number of edges since reset release).
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  fc;
    logic        fb;
    logic        de;
    logic        ls;
    logic        fs;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        vclk;
  } obs_t;

  // Configurations: 0 = defaults, 1..3 = small rasters exercising other parameters.
  localparam int HA  [4] = '{640, 8, 5, 12};
  localparam int HF  [4] = '{16,  2, 1, 3};
  localparam int HSY [4] = '{96,  3, 2, 4};
  localparam int HB  [4] = '{48,  3, 2, 2};
  localparam int VA  [4] = '{480, 6, 4, 5};
  localparam int VF  [4] = '{10,  1, 1, 2};
  localparam int VSY [4] = '{2,   2, 1, 3};
  localparam int VB  [4] = '{33,  1, 2, 2};
  localparam int HP  [4] = '{0, 1, 0, 1};
  localparam int VP  [4] = '{0, 1, 1, 0};
  localparam int CW  [4] = '{6, 5, 2, 8};
  localparam int PL  [4] = '{1, 3, 0, 7};
  localparam int FW  [4] = '{6, 2, 3, 4};
  localparam int HT  [4] = '{800, 16, 10, 21};
  localparam int VT  [4] = '{525, 10, 8, 12};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   pos = 0;
  int   rin [4];
  int   gin [4];
  int   bin [4];

  always #5 clk = ~clk;

  vga_timing_gen_if #(.XW($clog2(HT[0])), .YW($clog2(VT[0])), .FC_W(FW[0]), .COLOR_W(CW[0])) b0 ();
  vga_timing_gen_if #(.XW($clog2(HT[1])), .YW($clog2(VT[1])), .FC_W(FW[1]), .COLOR_W(CW[1])) b1 ();
  vga_timing_gen_if #(.XW($clog2(HT[2])), .YW($clog2(VT[2])), .FC_W(FW[2]), .COLOR_W(CW[2])) b2 ();
  vga_timing_gen_if #(.XW($clog2(HT[3])), .YW($clog2(VT[3])), .FC_W(FW[3]), .COLOR_W(CW[3])) b3 ();

  vga_timing_gen #(.H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HSY[0]), .H_BP(HB[0]),
                   .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VSY[0]), .V_BP(VB[0]),
                   .HS_POL(HP[0]), .VS_POL(VP[0]), .COLOR_W(CW[0]), .PIPE_LAT(PL[0]), .FC_W(FW[0]))
    u0 (.clk(clk), .rst(rst), .bus(b0));
  vga_timing_gen #(.H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HSY[1]), .H_BP(HB[1]),
                   .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VSY[1]), .V_BP(VB[1]),
                   .HS_POL(HP[1]), .VS_POL(VP[1]), .COLOR_W(CW[1]), .PIPE_LAT(PL[1]), .FC_W(FW[1]))
    u1 (.clk(clk), .rst(rst), .bus(b1));
  vga_timing_gen #(.H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HSY[2]), .H_BP(HB[2]),
                   .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VSY[2]), .V_BP(VB[2]),
                   .HS_POL(HP[2]), .VS_POL(VP[2]), .COLOR_W(CW[2]), .PIPE_LAT(PL[2]), .FC_W(FW[2]))
    u2 (.clk(clk), .rst(rst), .bus(b2));
  vga_timing_gen #(.H_ACTIVE(HA[3]), .H_FP(HF[3]), .H_SYNC(HSY[3]), .H_BP(HB[3]),
                   .V_ACTIVE(VA[3]), .V_FP(VF[3]), .V_SYNC(VSY[3]), .V_BP(VB[3]),
                   .HS_POL(HP[3]), .VS_POL(VP[3]), .COLOR_W(CW[3]), .PIPE_LAT(PL[3]), .FC_W(FW[3]))
    u3 (.clk(clk), .rst(rst), .bus(b3));

  obs_t o0_w, o1_w, o2_w, o3_w;
  assign o0_w = {16'(b0.x_out), 16'(b0.y_out), 8'(b0.fc_out), b0.fb_en_out, b0.draw_en_out,
                 b0.line_start_out, b0.frame_start_out, b0.VGA_R, b0.VGA_G, b0.VGA_B,
                 b0.VGA_HS, b0.VGA_VS, b0.VGA_BLANK_N, b0.VGA_CLK};
  assign o1_w = {16'(b1.x_out), 16'(b1.y_out), 8'(b1.fc_out), b1.fb_en_out, b1.draw_en_out,
                 b1.line_start_out, b1.frame_start_out, b1.VGA_R, b1.VGA_G, b1.VGA_B,
                 b1.VGA_HS, b1.VGA_VS, b1.VGA_BLANK_N, b1.VGA_CLK};
  assign o2_w = {16'(b2.x_out), 16'(b2.y_out), 8'(b2.fc_out), b2.fb_en_out, b2.draw_en_out,
                 b2.line_start_out, b2.frame_start_out, b2.VGA_R, b2.VGA_G, b2.VGA_B,
                 b2.VGA_HS, b2.VGA_VS, b2.VGA_BLANK_N, b2.VGA_CLK};
  assign o3_w = {16'(b3.x_out), 16'(b3.y_out), 8'(b3.fc_out), b3.fb_en_out, b3.draw_en_out,
                 b3.line_start_out, b3.frame_start_out, b3.VGA_R, b3.VGA_G, b3.VGA_B,
                 b3.VGA_HS, b3.VGA_VS, b3.VGA_BLANK_N, b3.VGA_CLK};

  function automatic obs_t get(input int i);
    case (i)
      0:       return o0_w;
      1:       return o1_w;
      2:       return o2_w;
      default: return o3_w;
    endcase
  endfunction

  // Colour expansion by tiling the w-bit value repeatedly and keeping the top 8 bits.
  function automatic int exp8(input int c, input int w);
    int acc = 0;
    int bits = 0;
    while (bits < 8) begin
      acc  = (acc << w) | c;
      bits = bits + w;
    end
    return (acc >> (bits - 8)) & 255;
  endfunction

  // Expected outputs of configuration i after p active edges since reset release.
  function automatic obs_t model(input int i, input int p);
    obs_t e;
    int   x, y, q, dx, dy;
    logic den, hsa, vsa;
    e    = '0;
    x    = p % HT[i];
    y    = (p / HT[i]) % VT[i];
    e.x  = 16'(x);
    e.y  = 16'(y);
    e.fc = 8'((p / (HT[i] * VT[i])) % (1 << FW[i]));
    e.fb = (x < HA[i]) && (y < VA[i]);
    e.de = (y >= VA[i]);
    e.ls = (x == 0);
    e.fs = (x == 0) && (y == 0);
    den  = 1'b0;
    hsa  = 1'b0;
    vsa  = 1'b0;
    q    = p - 1 - PL[i];
    if (q >= 0) begin
      dx  = q % HT[i];
      dy  = (q / HT[i]) % VT[i];
      den = (dx < HA[i]) && (dy < VA[i]);
      hsa = (dx >= HA[i] + HF[i]) && (dx < HA[i] + HF[i] + HSY[i]);
      vsa = (dy >= VA[i] + VF[i]) && (dy < VA[i] + VF[i] + VSY[i]);
    end
    e.hs   = (HP[i] != 0) ? hsa : !hsa;
    e.vs   = (VP[i] != 0) ? vsa : !vsa;
    e.bn   = den;
    e.r    = den ? 8'(exp8(rin[i], CW[i])) : 8'h00;
    e.g    = den ? 8'(exp8(gin[i], CW[i])) : 8'h00;
    e.b    = den ? 8'(exp8(bin[i], CW[i])) : 8'h00;
    e.vclk = clk;
    return e;
  endfunction

  task automatic randomise_colours();
    for (int i = 0; i < 4; i++) begin
      rin[i] = $urandom_range((1 << CW[i]) - 1, 0);
      gin[i] = $urandom_range((1 << CW[i]) - 1, 0);
      bin[i] = $urandom_range((1 << CW[i]) - 1, 0);
    end
  endtask

  task automatic apply_colours();
    b0.r_in = 6'(rin[0]); b0.g_in = 6'(gin[0]); b0.b_in = 6'(bin[0]);
    b1.r_in = 5'(rin[1]); b1.g_in = 5'(gin[1]); b1.b_in = 5'(bin[1]);
    b2.r_in = 2'(rin[2]); b2.g_in = 2'(gin[2]); b2.b_in = 2'(bin[2]);
    b3.r_in = 8'(rin[3]); b3.g_in = 8'(gin[3]); b3.b_in = 8'(bin[3]);
  endtask

  task automatic step();
    @(posedge clk);
    pos = pos + 1;
    #1;
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pos = 0;
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst = 1'b1;
    pos = 0;
    randomise_colours();
    apply_colours();
    repeat (3) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        o = get(i); e = model(i, 0); vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL reset inst%0d got=%h want=%h", i, o, e);
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      o = get(i); e = model(i, 0); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL release inst%0d got=%h want=%h", i, o, e);
      end
    end
  endtask

  task automatic test_run(input int n);
    obs_t o, e;
    repeat (n) begin
      randomise_colours();
      apply_colours();
      step();
      for (int i = 0; i < 4; i++) begin
        o = get(i); e = model(i, pos); vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL run inst%0d pos=%0d got=%h want=%h", i, pos, o, e);
        end
      end
    end
  endtask

  task automatic test_mid_reset(input int k);
    obs_t o, e;
    test_run(k);
    #2;
    rst = 1'b1;
    pos = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      o = get(i); e = model(i, 0); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL async_reset inst%0d got=%h want=%h", i, o, e);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      o = get(i); e = model(i, 0); vectors++;
      if (o !== e || o.fs !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_release inst%0d got=%h want=%h", i, o, e);
      end
    end
  endtask

  task automatic test_colour();
    obs_t e1, e2;
    logic [7:0] w1, w2;
    hard_reset();
    randomise_colours();
    rin[1] = 16;
    rin[2] = 2;
    apply_colours();
    repeat (200) begin
      step();
      e1 = model(1, pos);
      e2 = model(2, pos);
      w1 = e1.bn ? 8'h84 : 8'h00;
      w2 = e2.bn ? 8'hAA : 8'h00;
      vectors += 2;
      if (b1.VGA_R !== w1) begin
        miscompares++;
        $display("FAIL colour_w5 pos=%0d got=%h want=%h", pos, b1.VGA_R, w1);
      end
      if (b2.VGA_R !== w2) begin
        miscompares++;
        $display("FAIL colour_w2 pos=%0d got=%h want=%h", pos, b2.VGA_R, w2);
      end
    end
  endtask

  task automatic test_fc_wrap();
    hard_reset();
    repeat (639) step();
    vectors++;
    if (b1.fc_out !== 2'd3) begin
      miscompares++;
      $display("FAIL fc_before_wrap got=%0d want=3", b1.fc_out);
    end
    step();
    vectors++;
    if (b1.fc_out !== 2'd0) begin
      miscompares++;
      $display("FAIL fc_wrap got=%0d want=0", b1.fc_out);
    end
  endtask

  task automatic test_hsync();
    int hs_first = -1;
    int hs_low = 0;
    hard_reset();
    repeat (900) begin
      step();
      if (b0.VGA_HS === 1'b0) begin
        if (hs_first < 0) hs_first = pos;
        hs_low++;
      end
      if (pos == 799) begin
        vectors++;
        if (b0.x_out !== 10'd799 || b0.y_out !== 10'd0) begin
          miscompares++;
          $display("FAIL line_end got x=%0d y=%0d want x=799 y=0", b0.x_out, b0.y_out);
        end
      end
      if (pos == 800) begin
        vectors++;
        if (b0.x_out !== 10'd0 || b0.y_out !== 10'd1) begin
          miscompares++;
          $display("FAIL line_wrap got x=%0d y=%0d want x=0 y=1", b0.x_out, b0.y_out);
        end
      end
    end
    vectors += 2;
    if (hs_first != 658) begin
      miscompares++;
      $display("FAIL hs_start got=%0d want=658", hs_first);
    end
    if (hs_low != 96) begin
      miscompares++;
      $display("FAIL hs_width got=%0d want=96", hs_low);
    end
  endtask

  initial begin
    test_reset();
    test_run(1500);
    test_mid_reset($urandom_range(400, 50));
    test_run(400);
    test_mid_reset($urandom_range(400, 50));
    test_run(300);
    test_colour();
    test_fc_wrap();
    test_hsync();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 visible px; H_FP 16; H_SYNC 96; H_BP 48; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33.
REQ-002 Parameters: HS_POL 0 (0 = active-low sync pin); VS_POL 0; COLOR_W 6 (input colour bits, 1..8); PIPE_LAT 1 (source read latency, 0..7); FC_W 6 (frame counter width).
REQ-003 Derived constants: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; XW = clog2(H_TOTAL); YW = clog2(V_TOTAL).
REQ-004 clk input 1: pixel clock. rst input 1: reset, asynchronous, active-high.
REQ-005 x_out output XW, y_out output YW: current pixel counters.
REQ-006 fc_out output FC_W: frame counter. fb_en_out output 1: current counters inside the active area. draw_en_out output 1: current line in vertical blank.
REQ-007 line_start_out output 1, frame_start_out output 1: one-cycle strobes.
REQ-008 r_in, g_in, b_in input COLOR_W each: pixel colour, returned PIPE_LAT cycles after x_out/y_out.
REQ-009 VGA_CLK output 1 (= clk); VGA_R/G/B output 8 each; VGA_HS, VGA_VS output 1; VGA_BLANK_N output 1.

Function
REQ-010 x SHALL increment every cycle and wrap from H_TOTAL-1 to 0; y SHALL increment on each x wrap and wrap from V_TOTAL-1 to 0.
REQ-011 fc SHALL increment modulo 2^FC_W when x = H_TOTAL-1 and y = V_TOTAL-1 in the same cycle.
REQ-012 fb_en_out = (x < H_ACTIVE) & (y < V_ACTIVE); draw_en_out = (y >= V_ACTIVE); both combinational from the current counters, undelayed.
REQ-013 line_start_out = (x = 0); frame_start_out = (x = 0) & (y = 0).
REQ-014 Internal hsync active iff H_ACTIVE+H_FP <= x <= H_ACTIVE+H_FP+H_SYNC-1; vsync active iff V_ACTIVE+V_FP <= y <= V_ACTIVE+V_FP+V_SYNC-1.
REQ-015 den, hsync, vsync SHALL be registered once, then delayed PIPE_LAT further register stages; outputs at cycle t reflect counters of cycle t-1-PIPE_LAT.
REQ-016 VGA_HS = delayed hsync XOR ~HS_POL; VGA_VS likewise with VS_POL; VGA_BLANK_N = delayed den.
REQ-017 VGA_R/G/B = delayed den ? colour expanded to 8 bits : 0; r_in/g_in/b_in are sampled combinationally in the same cycle.
REQ-018 Colour expansion: input MSB-aligned, low bits filled by repeating the input bits from the MSB down, so all-ones maps to 8'hFF and zero maps to 8'h00; COLOR_W = 8 passes unchanged.
REQ-019 Sync and blank SHALL never glitch at wrap; a counter wrap and an fc increment in the same cycle SHALL both take effect.

Reset
REQ-020 On rst: x = 0, y = 0, fc = 0; all delay stages cleared (den = 0, syncs inactive).
REQ-021 During rst: VGA_HS/VGA_VS at inactive pin level; VGA_R/G/B = 0; VGA_BLANK_N = 0; strobes are those of counter (0,0).
REQ-022 rst asserted mid-frame SHALL abort the frame; after rst deassertion, the first clock edge advances x to 1.

Structure
REQ-023 Timing defaults, derived totals and the expansion rule belong in shared package vga_pkg, for reuse by the framebuffer reader.
REQ-024 One sub-module, vga_delay_line (parametrised width and depth, async reset to a parameter value), implements the PIPE_LAT alignment.

Verification
REQ-025 Defaults, release rst: x wraps 799->0 and y increments; frame period = 420000 cycles; fc reaches 1 at cycle 420000.
REQ-026 Defaults: VGA_HS low for exactly 96 cycles, starting 2 cycles after x = 656; VGA_VS low for 2 lines, starting at y = 490.
REQ-027 PIPE_LAT = 3, r_in = 6'h3F throughout: VGA_R = 8'hFF for exactly 640 cycles per visible line, first nonzero 4 cycles after x = 0, y = 0; 0 during blank.
REQ-028 COLOR_W = 5, r_in = 5'b10000 -> VGA_R = 8'h84; COLOR_W = 2, r_in = 2'b10 -> VGA_R = 8'hAA.
REQ-029 HS_POL = 1: VGA_HS high only during the sync window; FC_W = 2: fc wraps 3 -> 0 after four frames.
REQ-030 rst pulsed at x = 300, y = 200: all outputs reach reset values asynchronously; the next frame_start_out occurs one cycle after release.
